// File: rtl/toggle_decoder_pkg.sv
// Shared definitions for the toggle-link receiver.
// Holds default parameter values and the queued event record layout
// {level after toggle, gap in clk edges since previous accepted toggle}.
package toggle_decoder_pkg;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 3;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_TS_W          = 8;
  localparam int DEF_FIFO_DEPTH    = 4;

  typedef struct packed {
    logic                level;
    logic [DEF_TS_W-1:0] gap;
  } ev_rec_t;
endpackage

// File: rtl/toggle_decoder_if.sv
// Signal bundle between a toggle_decoder and its environment.
//   t_in/clr_cnt/ev_ready       : driven by the environment (master)
//   toggle_pulse/level/count    : status from the decoder (slave)
//   ev_valid/ev_level/ev_gap    : event queue head, popped on ev_valid&&ev_ready
//   overflow                    : sticky queue-drop flag
interface toggle_decoder_if
  import toggle_decoder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TS_W  = DEF_TS_W
);
  logic             t_in;
  logic             clr_cnt;
  logic             toggle_pulse;
  logic             level;
  logic [CNT_W-1:0] toggle_count;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_level;
  logic [TS_W-1:0]  ev_gap;
  logic             overflow;

  modport master (
    output t_in, clr_cnt, ev_ready,
    input  toggle_pulse, level, toggle_count, ev_valid, ev_level, ev_gap, overflow
  );

  modport slave (
    input  t_in, clr_cnt, ev_ready,
    output toggle_pulse, level, toggle_count, ev_valid, ev_level, ev_gap, overflow
  );
endinterface

// File: rtl/toggle_decoder_sync_fifo.sv
// Small synchronous FIFO for event records.
//   clk_i, rst_ni : clock, async active-low reset (pointers only)
//   push_i/data_i : write request; ignored when full unless a pop happens too
//   pop_i         : consumer ready; pops only when not empty
//   data_o        : head record, forced to 0 while empty
//   full_o/empty_o: occupancy flags
module toggle_decoder_sync_fifo
  import toggle_decoder_pkg::*;
#(
  parameter int W     = DEF_TS_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/toggle_decoder.sv
// Receiver for a toggle-signalled event link.
//   clk, reset : clock, async active-low reset
//   bus        : toggle_decoder_if.slave (t_in, clr_cnt, ev_ready in;
//                toggle_pulse, level, toggle_count, ev_* and overflow out)
// t_in is synchronised, glitch-filtered, and each accepted level change
// produces a one-cycle pulse, a count increment and a queued {level, gap}.
module toggle_decoder
  import toggle_decoder_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TS_W          = DEF_TS_W,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  toggle_decoder_if.slave   bus
);
  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int RW = TS_W + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   level_q, level_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   pulse_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TS_W-1:0]        gcnt_q, gcnt_d, gsat, gap_rec;
  logic                   seen_q;
  logic                   ovf_q, ovf_d;
  logic                   accept, pop, drop;
  logic                   full, empty;
  logic [RW-1:0]          head;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept  = 1'b0;
    level_d = level_q;
    fcnt_d  = '0;
    // Persistence counter only runs while the synchronised level disagrees.
    if (s != level_q) begin
      if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
        accept  = 1'b1;
        level_d = s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    gsat    = (gcnt_q == '1) ? gcnt_q : gcnt_q + TS_W'(1);
    // No previous event after reset, so the first gap is reported as 0.
    gap_rec = seen_q ? gsat : '0;
    gcnt_d  = accept ? '0 : gsat;

    pop  = !empty && bus.ev_ready;
    drop = accept && full && !pop;

    cnt_d = cnt_q;
    if (bus.clr_cnt)  cnt_d = accept ? CNT_W'(1) : '0;
    else if (accept)  cnt_d = cnt_q + CNT_W'(1);

    ovf_d = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_cnt) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      fcnt_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.t_in};
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
      pulse_q <= accept;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      if (accept) seen_q <= 1'b1;
      ovf_q   <= ovf_d;
    end
  end

  toggle_decoder_sync_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (accept),
    .data_i  ({s, gap_rec}),
    .pop_i   (bus.ev_ready),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.toggle_pulse = pulse_q;
  assign bus.level        = level_q;
  assign bus.toggle_count = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.ev_valid     = !empty;
  assign bus.ev_level     = head[RW-1];
  assign bus.ev_gap       = head[TS_W-1:0];
endmodule

// File: tb/tb_toggle_decoder.sv
module tb_toggle_decoder;
  import toggle_decoder_pkg::*;

  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int CW    = 8;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int GMAX  = (1 << TW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  toggle_decoder_if #(.CNT_W(CW), .TS_W(TW)) bus();

  toggle_decoder #(
    .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .CNT_W(CW), .TS_W(TW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: sample history, disagreement run length, event list.
  bit      samp[$];
  int      m_run, m_cnt, edge_n, last_n;
  bit      m_lvl, m_pulse, m_ovf, m_seen;
  ev_rec_t m_q[$];

  function automatic void m_reset();
    samp.delete();
    m_q.delete();
    m_run = 0; m_cnt = 0; edge_n = 0; last_n = 0;
    m_lvl = 0; m_pulse = 0; m_ovf = 0; m_seen = 0;
  endfunction

  function automatic void m_step(bit t, bit clr, bit rdy);
    bit s, acc, pop, drop;
    int gap;
    // Level seen by the filter at this edge: t_in sampled SYNC edges earlier.
    s = (samp.size() >= SYNC) ? samp[SYNC-1] : 1'b0;
    samp.push_front(t);
    if (samp.size() > SYNC) void'(samp.pop_back());
    edge_n++;
    acc = (s != m_lvl) && (m_run == FILT - 1);
    if (s == m_lvl) m_run = 0;
    else if (acc) begin m_lvl = s; m_run = 0; end
    else m_run++;
    m_pulse = acc;
    pop  = rdy && (m_q.size() > 0);
    drop = acc && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      gap = m_seen ? ((edge_n - last_n > GMAX) ? GMAX : edge_n - last_n) : 0;
      if (!drop) m_q.push_back(ev_rec_t'{level: s, gap: TW'(gap)});
      last_n = edge_n;
      m_seen = 1;
    end
    if (clr)      m_cnt = acc ? 1 : 0;
    else if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
  endfunction

  task automatic cmp_all();
    chk("pulse", bus.toggle_pulse, m_pulse);
    chk("level", bus.level, m_lvl);
    chk("count", bus.toggle_count, m_cnt);
    chk("ovf", bus.overflow, m_ovf);
    chk("ev_valid", bus.ev_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("ev_level", bus.ev_level, m_q[0].level);
      chk("ev_gap", bus.ev_gap, m_q[0].gap);
    end
  endtask

  task automatic cmp_zero(input string tag);
    chk({tag, "_pulse"}, bus.toggle_pulse, 0);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_count"}, bus.toggle_count, 0);
    chk({tag, "_valid"}, bus.ev_valid, 0);
    chk({tag, "_evlvl"}, bus.ev_level, 0);
    chk({tag, "_evgap"}, bus.ev_gap, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
  endtask

  task automatic cyc(input bit t, input bit clr, input bit rdy);
    @(negedge clk);
    bus.t_in = t; bus.clr_cnt = clr; bus.ev_ready = rdy;
    @(posedge clk);
    m_step(t, clr, rdy);
    #1;
    cmp_all();
  endtask

  task automatic hold(input bit t, input int n, input bit rdy);
    repeat (n) cyc(t, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 cmp_zero("rst");
    m_reset();
    bus.t_in = 1'b0; bus.clr_cnt = 1'b0; bus.ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, len, bias;
    bit t;
    bus.t_in = 1'b0; bus.clr_cnt = 1'b0; bus.ev_ready = 1'b0;
    m_reset();
    #2 reset = 1'b0;
    #1 cmp_zero("init");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Short glitch: two cycles high is never accepted.
    hold(1, 2, 0);
    hold(0, 6, 0);
    chk("glitch_cnt", bus.toggle_count, 0);
    chk("glitch_vld", bus.ev_valid, 0);

    // Clean rising toggle: accepted on the 5th edge.
    hold(1, 4, 0);
    chk("rise_early", bus.toggle_pulse, 0);
    cyc(1, 0, 0);
    chk("rise_pulse", bus.toggle_pulse, 1);
    chk("rise_level", bus.level, 1);
    chk("rise_cnt", bus.toggle_count, 1);
    chk("rise_vld", bus.ev_valid, 1);
    chk("rise_evlvl", bus.ev_level, 1);
    chk("rise_gap", bus.ev_gap, 0);
    cyc(1, 0, 0);
    chk("rise_1cyc", bus.toggle_pulse, 0);

    // Second toggle accepted 20 edges after the first.
    hold(1, 14, 0);
    hold(0, 5, 0);
    chk("gap20_pulse", bus.toggle_pulse, 1);
    cyc(0, 0, 1);
    chk("gap20_lvl", bus.ev_level, 0);
    chk("gap20_gap", bus.ev_gap, 20);

    // Long idle saturates the gap.
    hold(0, 300, 1);
    hold(1, 5, 0);
    chk("sat_lvl", bus.ev_level, 1);
    chk("sat_gap", bus.ev_gap, GMAX);

    // Queue three events, then reset mid-cycle.
    hold(1, 3, 0);
    hold(0, 8, 0);
    hold(1, 8, 0);
    chk("pre_rst_cnt", bus.toggle_count, 5);
    do_reset();
    hold(0, 4, 1);
    chk("post_rst_vld", bus.ev_valid, 0);

    // Five toggles with no consumer: one drop.
    for (int i = 0; i < 5; i++) hold(i % 2 == 0, 8, 0);
    chk("fill_cnt", bus.toggle_count, 5);
    chk("fill_ovf", bus.overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_lvl", bus.ev_level, (i % 2 == 0));
      cyc(1, 0, 1);
    end
    chk("drain_empty", bus.ev_valid, 0);

    // Full queue with push and pop together: no drop.
    cyc(1, 1, 0);
    chk("clr_ovf", bus.overflow, 0);
    chk("clr_cnt", bus.toggle_count, 0);
    for (int i = 0; i < 4; i++) hold(i % 2 != 0, 8, 0);
    hold(0, 4, 0);
    cyc(0, 0, 1);
    chk("pp_pulse", bus.toggle_pulse, 1);
    chk("pp_ovf", bus.overflow, 0);
    hold(0, 3, 0);
    n = 0;
    while (bus.ev_valid && n < 10) begin
      cyc(0, 0, 1);
      n++;
    end
    chk("pp_occ", n, 4);

    // clr_cnt coincident with accept, then with accept plus drop.
    for (int i = 0; i < 5; i++) hold(i % 2 == 0, 8, 0);
    chk("drop_ovf", bus.overflow, 1);
    hold(0, 4, 0);
    cyc(0, 1, 1);
    chk("clracc_cnt", bus.toggle_count, 1);
    chk("clracc_ovf", bus.overflow, 0);
    hold(1, 4, 0);
    cyc(1, 1, 0);
    chk("clrdrop_cnt", bus.toggle_count, 1);
    chk("clrdrop_ovf", bus.overflow, 1);
    hold(1, 6, 1);

    // Randomised traffic against the model.
    t = 1'b1;
    n = 0;
    bias = 2;
    while (n < 1500) begin
      if ($urandom_range(0, 1) != 0) t = ~t;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 15) == 0) bias = $urandom_range(0, 4);
      repeat (len) cyc(t, $urandom_range(0, 39) == 0, $urandom_range(0, 3) < bias);
      n += len;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/toggle_decoder.md
Name: toggle_decoder

Overview:
Receive end of a toggle-signalled event link. The far end flips a level with a T flip-flop once per event; this block recovers the events. It synchronises the asynchronous toggle level, rejects glitches with a stability filter, emits a one-cycle pulse per accepted toggle and keeps a running toggle count. Each event is queued as a record holding the new level and the inter-event gap, drained through a valid/ready interface.

Parameters:
SYNC_STAGES, 2, synchroniser flops on t_in (>=2)
FILTER_CYCLES, 3, consecutive cycles a changed level must persist before acceptance (>=1)
CNT_W, 8, width of toggle_count
TS_W, 8, width of gap field
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)

Ports:
clk  in  1  single clock
reset  in  1  one clock; reset is asynchronous and active-low
t_in  in  1  toggle level from far end, asynchronous to clk
clr_cnt  in  1  synchronous clear of toggle_count and overflow
toggle_pulse  out  1  high one cycle per accepted toggle
level  out  1  filtered, synchronised level
toggle_count  out  CNT_W  accepted toggles, wraps modulo 2^CNT_W
ev_valid  out  1  queue head valid
ev_ready  in  1  consumer accepts head
ev_level  out  1  head record: level after the toggle
ev_gap  out  TS_W  head record: clk edges since previous accepted toggle
overflow  out  1  sticky: an event was dropped on a full queue

Behaviour:
- Reset (reset=0, async): sync chain, level, filter counter, gap counter, first-event flag, toggle_count, overflow, FIFO pointers all 0. All outputs 0. Queue contents discarded.
- Sync: t_in shifts through SYNC_STAGES flops; s = last stage.
- Filter: fcnt clears when s==level. When s!=level and fcnt==FILTER_CYCLES-1: accept (level<=s, fcnt<=0). Otherwise, while s!=level, fcnt increments. A toggle held stable is accepted on the (SYNC_STAGES+FILTER_CYCLES)-th edge after t_in changes. Shorter pulses are ignored.
- Accept edge: toggle_pulse<=1 for exactly one cycle. toggle_count increments. A record {level_new, gap} is pushed.
- Gap: gcnt increments every edge, saturating at 2^TS_W-1. On accept, the recorded gap is gcnt+1 (saturated), then gcnt<=0. The first event after reset records gap=0 via the first-event flag.
- Queue: registered storage. ev_valid=!empty; head is driven on ev_level/ev_gap. Pop on ev_valid&&ev_ready.
- Latency: a record pushed at edge k is visible with ev_valid=1 after edge k, coincident with toggle_pulse.
- Full queue with push and no pop: record dropped, overflow<=1. toggle_count still increments.
- Full queue with push and pop in the same cycle: both occur, no overflow.
- Empty queue with ev_ready=1: no effect.
- ev_level/ev_gap hold stable while ev_valid&&!ev_ready.
- clr_cnt: toggle_count<=0 and overflow<=0. If an accept occurs in the same cycle, toggle_count<=1. If a drop occurs in the same cycle, overflow<=1 (set wins). clr_cnt does not touch the queue.
- Reset released with t_in=1: level=0 mismatches, so a rising event is reported after SYNC_STAGES+FILTER_CYCLES edges. This is required behaviour.
- Reset asserted mid-operation: immediate clear, including any in-flight filter count.

Decomposition:
- Shared package holds the event record type {level, gap[TS_W]} and default parameter constants.
- One sub-module is natural: sync_fifo (FIFO_DEPTH x record, valid/ready pop, full/empty flags, simultaneous push/pop support).
- Synchroniser, filter, counters and gap counter live in the top module.

Test Plan:
1. Reset asserted mid-run with 3 queued events -> all outputs 0 immediately, ev_valid=0 after release with t_in=0.
2. t_in 0->1 held -> level and toggle_pulse rise on the 5th edge; pulse lasts 1 cycle; toggle_count=1; ev_valid=1 with ev_level=1, ev_gap=0.
3. t_in high for 2 cycles then low -> no pulse, toggle_count stays 0, ev_valid stays 0.
4. Second toggle accepted 20 edges after the first -> second record ev_level=0, ev_gap=20. Gap of 300 edges -> ev_gap=255.
5. ev_ready=0, 5 well-spaced toggles -> toggle_count=5, overflow=1. Drain yields levels 1,0,1,0, then ev_valid=0.
6. Queue full, toggle accepted with ev_ready=1 in the same cycle -> overflow stays 0, occupancy stays 4. Then clr_cnt coincident with an accept -> toggle_count=1, overflow=0.
